// File: rtl/packet_ingress_buffer.sv
// Store-and-forward ingress FIFO: commits clean MAC packets, rewinds and drops bad ones.
// Optional macro DROP_STATS_EN builds the saturating dropped-packet counter on drop_count.
module packet_ingress_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 6
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_error,
  output logic                  in_ready,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_eop,
  output logic                  rdempty,
  output logic [ADDR_BITS:0]    pkt_pending,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int PW    = ADDR_BITS + 1;
  localparam logic [PW-1:0] DEPTH_PTR = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           wr_commit_q, wr_commit_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           pkt_pending_q, pkt_pending_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rd_eop_q, rd_eop_d;
  logic                    overflow_q, overflow_d;
  logic                    in_ready_q;
  logic [DATA_WIDTH:0]     mem_q [DEPTH];

  logic                    beat;
  logic                    pkt_beat;
  logic                    dup;
  logic                    full;
  logic                    bad;
  logic                    we;
  logic                    commit;
  logic                    rd_fire;
  logic                    rd_word_eop;
  logic [PW-1:0]           wbase;

  // Write FSM, pointer and read-side next-state logic.
  always_comb begin
    beat        = in_valid & in_ready_q;
    dup         = (state_q == RECEIVE) & in_sop;
    // A duplicate sop restarts from the last commit point, so space is judged from there.
    wbase       = dup ? wr_commit_q : wr_ptr_q;
    full        = ((wbase - rd_ptr_q) == DEPTH_PTR);
    pkt_beat    = beat & ((state_q == RECEIVE) | ((state_q == IDLE) & in_sop));
    bad         = in_error | full;
    rdempty     = (rd_ptr_q == wr_commit_q);
    rd_fire     = rdreq & ~rdempty;
    rd_word_eop = mem_q[rd_ptr_q[ADDR_BITS-1:0]][DATA_WIDTH];

    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    we          = 1'b0;
    commit      = 1'b0;
    overflow_d  = 1'b0;

    case (state_q)
      IDLE, RECEIVE: begin
        if (!pkt_beat) begin
          state_d = state_q;
        end else if (bad) begin
          wr_ptr_d   = wr_commit_q;
          overflow_d = ~in_error;
          state_d    = in_eop ? IDLE : DROP;
        end else begin
          we       = 1'b1;
          wr_ptr_d = wbase + PTR_ONE;
          if (in_eop) begin
            commit      = 1'b1;
            wr_commit_d = wbase + PTR_ONE;
            state_d     = IDLE;
          end else begin
            state_d = RECEIVE;
          end
        end
      end
      DROP: begin
        if (beat && in_eop) begin
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d  = IDLE;
        wr_ptr_d = wr_commit_q;
      end
    endcase

    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      rdata_d  = mem_q[rd_ptr_q[ADDR_BITS-1:0]][DATA_WIDTH-1:0];
      rd_eop_d = rd_word_eop;
    end else begin
      rd_ptr_d = rd_ptr_q;
      rdata_d  = rdata_q;
      rd_eop_d = rd_eop_q;
    end

    case ({commit, rd_fire & rd_word_eop})
      2'b10:   pkt_pending_d = pkt_pending_q + PTR_ONE;
      2'b01:   pkt_pending_d = pkt_pending_q - PTR_ONE;
      default: pkt_pending_d = pkt_pending_q;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      wr_commit_q   <= '0;
      rd_ptr_q      <= '0;
      pkt_pending_q <= '0;
      rdata_q       <= '0;
      rd_eop_q      <= 1'b0;
      overflow_q    <= 1'b0;
      in_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_commit_q   <= wr_commit_d;
      rd_ptr_q      <= rd_ptr_d;
      pkt_pending_q <= pkt_pending_d;
      rdata_q       <= rdata_d;
      rd_eop_q      <= rd_eop_d;
      overflow_q    <= overflow_d;
      in_ready_q    <= 1'b1;
    end
  end

  // Packet storage of {eop, data}.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wbase[ADDR_BITS-1:0]] <= {in_eop, in_data};
    end
  end

`ifdef DROP_STATS_EN
  logic [15:0] drop_count_q, drop_count_d;
  logic [16:0] drop_sum;

  // A duplicate sop that is itself bad drops two packets on one beat.
  always_comb begin
    drop_sum = {1'b0, drop_count_q} + {16'd0, dup} + {16'd0, pkt_beat & bad};
    if (drop_sum[16]) begin
      drop_count_d = 16'hFFFF;
    end else begin
      drop_count_d = drop_sum[15:0];
    end
  end

  // Saturating dropped-packet counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      drop_count_q <= 16'd0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = 16'd0;
`endif

  assign in_ready    = in_ready_q;
  assign rdata       = rdata_q;
  assign rd_eop      = rd_eop_q;
  assign pkt_pending = pkt_pending_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_packet_ingress_buffer.sv
// Directed bench for packet_ingress_buffer: a DEPTH-64 instance and a DEPTH-8 instance share stimulus.
module tb_packet_ingress_buffer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] in_data;
  logic        in_valid, in_sop, in_eop, in_error, rdreq;

  logic        b_in_ready, b_rd_eop, b_rdempty, b_overflow;
  logic [31:0] b_rdata;
  logic [6:0]  b_pkt_pending;
  logic [15:0] b_drop_count;

  logic        s_in_ready, s_rd_eop, s_rdempty, s_overflow;
  logic [31:0] s_rdata;
  logic [3:0]  s_pkt_pending;
  logic [15:0] s_drop_count;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_drop1;

  always #5 clk = ~clk;

  packet_ingress_buffer #(.DATA_WIDTH(32), .ADDR_BITS(6)) dut (
    .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_valid(in_valid),
    .in_sop(in_sop), .in_eop(in_eop), .in_error(in_error), .in_ready(b_in_ready),
    .rdreq(rdreq), .rdata(b_rdata), .rd_eop(b_rd_eop), .rdempty(b_rdempty),
    .pkt_pending(b_pkt_pending), .overflow(b_overflow), .drop_count(b_drop_count)
  );

  packet_ingress_buffer #(.DATA_WIDTH(32), .ADDR_BITS(3)) dut_small (
    .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_valid(in_valid),
    .in_sop(in_sop), .in_eop(in_eop), .in_error(in_error), .in_ready(s_in_ready),
    .rdreq(rdreq), .rdata(s_rdata), .rd_eop(s_rd_eop), .rdempty(s_rdempty),
    .pkt_pending(s_pkt_pending), .overflow(s_overflow), .drop_count(s_drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    in_data = 32'd0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0; rdreq = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic sop, input logic eop, input logic err);
    in_data = d; in_valid = 1'b1; in_sop = sop; in_eop = eop; in_error = err;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
  endtask

  task automatic rd_big(input string tag, input logic [31:0] d, input logic e);
    rdreq = 1'b1;
    @(posedge clk);
    #1;
    rdreq = 1'b0;
    chk({tag, "_data"}, b_rdata, d);
    chk({tag, "_eop"}, 32'(b_rd_eop), 32'(e));
  endtask

  initial begin : main
    logic [32:0] exp_q[$];
    logic [32:0] ent;
    logic [31:0] last_data;
    logic        last_eop, fire;
    int          nb, nread, peak;

`ifdef DROP_STATS_EN
    exp_drop1 = 16'd1;
`else
    exp_drop1 = 16'd0;
`endif

    // Reset values while held and just after release
    n_rst = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(b_in_ready), 32'd0);
    chk("rst_rdempty", 32'(b_rdempty), 32'd1);
    chk("rst_pending", 32'(b_pkt_pending), 32'd0);
    chk("rst_rdata", b_rdata, 32'd0);
    chk("rst_rd_eop", 32'(b_rd_eop), 32'd0);
    chk("rst_overflow", 32'(b_overflow), 32'd0);
    chk("rst_drop", 32'(b_drop_count), 32'd0);
    n_rst = 1'b1;
    #1;
    chk("rel_in_ready_low", 32'(b_in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_high", 32'(b_in_ready), 32'd1);

    // Clean 4-word packet
    beat(32'hA0, 1'b1, 1'b0, 1'b0);
    beat(32'hA1, 1'b0, 1'b0, 1'b0);
    beat(32'hA2, 1'b0, 1'b0, 1'b0);
    chk("clean_uncommitted_empty", 32'(b_rdempty), 32'd1);
    beat(32'hA3, 1'b0, 1'b1, 1'b0);
    chk("clean_rdempty", 32'(b_rdempty), 32'd0);
    chk("clean_pending", 32'(b_pkt_pending), 32'd1);
    rd_big("clean_r0", 32'hA0, 1'b0);
    rd_big("clean_r1", 32'hA1, 1'b0);
    rd_big("clean_r2", 32'hA2, 1'b0);
    rd_big("clean_r3", 32'hA3, 1'b1);
    chk("clean_pending_end", 32'(b_pkt_pending), 32'd0);
    chk("clean_rdempty_end", 32'(b_rdempty), 32'd1);
    rd_big("clean_empty_hold", 32'hA3, 1'b1);

    // Errored packet then clean 2-word packet
    do_reset();
    beat(32'hB0, 1'b1, 1'b0, 1'b0);
    beat(32'hB1, 1'b0, 1'b0, 1'b0);
    beat(32'hB2, 1'b0, 1'b1, 1'b1);
    chk("err_rdempty", 32'(b_rdempty), 32'd1);
    chk("err_pending", 32'(b_pkt_pending), 32'd0);
    chk("err_drop", 32'(b_drop_count), 32'(exp_drop1));
    chk("err_no_overflow", 32'(b_overflow), 32'd0);
    beat(32'hC0, 1'b1, 1'b0, 1'b0);
    beat(32'hC1, 1'b0, 1'b1, 1'b0);
    chk("err_next_pending", 32'(b_pkt_pending), 32'd1);
    rd_big("err_r0", 32'hC0, 1'b0);
    rd_big("err_r1", 32'hC1, 1'b1);

    // Duplicate sop
    do_reset();
    beat(32'h11, 1'b1, 1'b0, 1'b0);
    beat(32'h12, 1'b0, 1'b0, 1'b0);
    beat(32'h21, 1'b1, 1'b0, 1'b0);
    beat(32'h22, 1'b0, 1'b1, 1'b0);
    chk("dup_pending", 32'(b_pkt_pending), 32'd1);
    chk("dup_drop", 32'(b_drop_count), 32'(exp_drop1));
    rd_big("dup_r0", 32'h21, 1'b0);
    rd_big("dup_r1", 32'h22, 1'b1);
    chk("dup_rdempty_end", 32'(b_rdempty), 32'd1);

    // Overrun on the DEPTH-8 instance
    do_reset();
    for (int i = 0; i < 10; i++) begin
      beat(32'h30 + 32'(i), (i == 0), (i == 9), 1'b0);
      chk($sformatf("ovr_overflow_%0d", i), 32'(s_overflow), (i == 8) ? 32'd1 : 32'd0);
      chk($sformatf("ovr_rdempty_%0d", i), 32'(s_rdempty), 32'd1);
    end
    beat(32'h40, 1'b1, 1'b0, 1'b0);
    beat(32'h41, 1'b0, 1'b1, 1'b0);
    chk("ovr_next_pending", 32'(s_pkt_pending), 32'd1);
    chk("ovr_next_rdempty", 32'(s_rdempty), 32'd0);
    chk("ovr_drop", 32'(s_drop_count), 32'(exp_drop1));
    rdreq = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_r0_data", s_rdata, 32'h40);
    chk("ovr_r0_eop", 32'(s_rd_eop), 32'd0);
    @(posedge clk);
    #1;
    rdreq = 1'b0;
    chk("ovr_r1_data", s_rdata, 32'h41);
    chk("ovr_r1_eop", 32'(s_rd_eop), 32'd1);

    // Concurrent traffic: two 8-word packets with continuous rdreq
    do_reset();
    nb = 0; nread = 0; peak = 0;
    last_data = 32'd0; last_eop = 1'b0;
    for (int cyc = 0; cyc < 80 && !(nb == 16 && nread == 16); cyc++) begin
      if (nb < 16) begin
        in_data  = (nb < 8) ? (32'h50 + 32'(nb)) : (32'h60 + 32'(nb - 8));
        in_valid = 1'b1;
        in_sop   = (nb % 8 == 0);
        in_eop   = (nb % 8 == 7);
        exp_q.push_back({in_eop, in_data});
      end else begin
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      end
      rdreq = 1'b1;
      fire  = ~b_rdempty;
      @(posedge clk);
      #1;
      if (nb < 16) nb++;
      if (fire) begin
        if (exp_q.size() == 0) begin
          chk("conc_spurious_read", 32'd1, 32'd0);
        end else begin
          ent = exp_q.pop_front();
          last_data = ent[31:0];
          last_eop  = ent[32];
          chk($sformatf("conc_data_%0d", nread), b_rdata, last_data);
          chk($sformatf("conc_eop_%0d", nread), 32'(b_rd_eop), 32'(last_eop));
        end
        nread++;
      end else begin
        chk("conc_hold_data", b_rdata, last_data);
      end
      if (int'(b_pkt_pending) > peak) peak = int'(b_pkt_pending);
    end
    idle_in();
    chk("conc_nread", 32'(nread), 32'd16);
    chk("conc_peak_le2", 32'(peak <= 2), 32'd1);
    chk("conc_pending_end", 32'(b_pkt_pending), 32'd0);
    chk("conc_rdempty_end", 32'(b_rdempty), 32'd1);

    // Reset mid-packet
    beat(32'h70, 1'b1, 1'b0, 1'b0);
    beat(32'h71, 1'b0, 1'b0, 1'b0);
    in_data = 32'h72; in_valid = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    chk("mid_in_ready", 32'(b_in_ready), 32'd0);
    chk("mid_rdempty", 32'(b_rdempty), 32'd1);
    chk("mid_pending", 32'(b_pkt_pending), 32'd0);
    chk("mid_rdata", b_rdata, 32'd0);
    chk("mid_rd_eop", 32'(b_rd_eop), 32'd0);
    chk("mid_overflow", 32'(b_overflow), 32'd0);
    chk("mid_drop", 32'(b_drop_count), 32'd0);
    idle_in();
    @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_in_ready_back", 32'(b_in_ready), 32'd1);
    beat(32'h73, 1'b0, 1'b0, 1'b0);
    beat(32'h74, 1'b0, 1'b1, 1'b0);
    chk("mid_tail_rdempty", 32'(b_rdempty), 32'd1);
    chk("mid_tail_pending", 32'(b_pkt_pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
